// File: rtl/tpu_acc_pkg.sv
// ============================================================================
// Module   : tpu_acc_pkg
// Brief    : Shared constants and clear-state type for the accumulator bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tpu_acc_pkg;

    localparam int ACC_LANES  = 3;
    localparam int ACC_LANE_W = 32;
    localparam int ACC_WORD_W = ACC_LANES * ACC_LANE_W;
    localparam int ACC_DEPTH  = 256;
    localparam int ACC_ADDR_W = 8;

    typedef enum logic [0:0] {
        ACC_IDLE     = 1'b0,
        ACC_CLEARING = 1'b1
    } acc_clr_state_t;

endpackage : tpu_acc_pkg

`default_nettype wire

// File: rtl/acc_mem_dp.sv
// ============================================================================
// Module   : acc_mem_dp
// Brief    : Accumulator storage, one write port (clear has priority) and two
//            synchronous read-before-write read ports. Contents are not reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module acc_mem_dp
    import tpu_acc_pkg::*;
#(
    parameter int DEPTH  = ACC_DEPTH,
    parameter int ADDR_W = ACC_ADDR_W,
    parameter int WORD_W = ACC_WORD_W
) (
    input  logic              clk,
    input  logic              clr_we,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              s2_we,
    input  logic [ADDR_W-1:0] s2_addr,
    input  logic [WORD_W-1:0] s2_data,
    input  logic              a_en,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [WORD_W-1:0] a_rdata,
    input  logic              b_en,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [WORD_W-1:0] b_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [WORD_W-1:0] w_wdata;

    // A clear write wins over a pipeline commit to the same edge.
    always_comb begin
        w_we    = clr_we | s2_we;
        w_waddr = clr_we ? clr_addr : s2_addr;
        w_wdata = clr_we ? '0 : s2_data;
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        if (a_en) begin
            a_rdata <= r_mem[a_addr];
        end
        if (b_en) begin
            b_rdata <= r_mem[b_addr];
        end
    end

endmodule : acc_mem_dp

`default_nettype wire

// File: rtl/accumulator_bank.sv
// ============================================================================
// Module   : accumulator_bank
// Brief    : 256 x 96-bit lane-wise accumulator with sequential clear,
//            two-stage read-modify-write and a registered read port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module accumulator_bank
    import tpu_acc_pkg::*;
#(
    parameter int DEPTH  = ACC_DEPTH,
    parameter int ADDR_W = ACC_ADDR_W,
    parameter int LANES  = ACC_LANES,
    parameter int LANE_W = ACC_LANE_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    acc_clear,
    output logic                    acc_clear_busy,
    output logic                    acc_clear_complete,
    input  logic                    acc_wr_en,
    input  logic [ADDR_W-1:0]       acc_wr_addr,
    input  logic [LANES*LANE_W-1:0] acc_wr_data,
    input  logic                    acc_accum,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [LANES*LANE_W-1:0] rd_data,
    output logic                    rd_valid
);

    localparam int                WORD_W      = LANES * LANE_W;
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    acc_clr_state_t    r_state;
    acc_clr_state_t    w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] w_clr_ptr_nxt;
    logic              r_clr_prev;
    logic              r_complete;
    logic              w_complete_nxt;
    logic              w_clr_start;
    logic              w_clearing;

    assign w_clearing  = (r_state == ACC_CLEARING);
    assign w_clr_start = acc_clear & ~r_clr_prev & ~w_clearing;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ACC_IDLE;
            r_clr_ptr  <= '0;
            r_clr_prev <= 1'b0;
            r_complete <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_ptr  <= w_clr_ptr_nxt;
            r_clr_prev <= acc_clear;
            r_complete <= w_complete_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_ptr_nxt  = r_clr_ptr;
        w_complete_nxt = 1'b0;
        case (r_state)
            ACC_IDLE: begin
                if (w_clr_start) begin
                    w_state_nxt   = ACC_CLEARING;
                    w_clr_ptr_nxt = '0;
                end
            end
            ACC_CLEARING: begin
                w_clr_ptr_nxt = r_clr_ptr + 1'b1;
                if (r_clr_ptr == c_last_addr) begin
                    w_state_nxt    = ACC_IDLE;
                    w_complete_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ACC_IDLE;
            end
        endcase
    end

    assign acc_clear_busy     = w_clearing;
    assign acc_clear_complete = r_complete;

    // ------------------------------------------------------------------
    // Read-modify-write pipeline
    // ------------------------------------------------------------------
    logic              w_s1_accept;
    logic              r_s1_valid;
    logic [ADDR_W-1:0] r_s1_addr;
    logic [WORD_W-1:0] r_s1_data;
    logic              r_s1_accum;
    logic              r_fwd_valid;
    logic [WORD_W-1:0] r_fwd_word;
    logic [WORD_W-1:0] w_rmw_rdata;
    logic [WORD_W-1:0] w_base;
    logic [WORD_W-1:0] w_sum;
    logic [WORD_W-1:0] w_new_word;

    assign w_s1_accept = acc_wr_en & ~w_clearing & ~w_clr_start;

    // The memory read issued alongside a same-address commit returns the
    // pre-commit word, so the committed result is captured for the next op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_addr   <= '0;
            r_s1_data   <= '0;
            r_s1_accum  <= 1'b0;
            r_fwd_valid <= 1'b0;
            r_fwd_word  <= '0;
        end else begin
            r_s1_valid  <= w_s1_accept;
            r_fwd_valid <= w_s1_accept & r_s1_valid & (r_s1_addr == acc_wr_addr);
            r_fwd_word  <= w_new_word;
            if (w_s1_accept) begin
                r_s1_addr  <= acc_wr_addr;
                r_s1_data  <= acc_wr_data;
                r_s1_accum <= acc_accum;
            end
        end
    end

    assign w_base = r_fwd_valid ? r_fwd_word : w_rmw_rdata;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_sum[l*LANE_W +: LANE_W] = w_base[l*LANE_W +: LANE_W]
                                         + r_s1_data[l*LANE_W +: LANE_W];
    end

    assign w_new_word = r_s1_accum ? w_sum : r_s1_data;

    // ------------------------------------------------------------------
    // External read port
    // ------------------------------------------------------------------
    logic              r_rd_valid;
    logic              r_rd_seen;
    logic [WORD_W-1:0] w_rd_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_seen  <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            r_rd_seen  <= r_rd_seen | rd_en;
        end
    end

    // The RAM output register has no reset; mask it until a read lands.
    assign rd_data  = r_rd_seen ? w_rd_rdata : '0;
    assign rd_valid = r_rd_valid;

    acc_mem_dp #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_mem (
        .clk      (clk),
        .clr_we   (w_clearing),
        .clr_addr (r_clr_ptr),
        .s2_we    (r_s1_valid),
        .s2_addr  (r_s1_addr),
        .s2_data  (w_new_word),
        .a_en     (w_s1_accept),
        .a_addr   (acc_wr_addr),
        .a_rdata  (w_rmw_rdata),
        .b_en     (rd_en),
        .b_addr   (rd_addr),
        .b_rdata  (w_rd_rdata)
    );

endmodule : accumulator_bank

`default_nettype wire

// File: doc/accumulator_bank.md
# accumulator_bank

Stores systolic-array column results as 96-bit words: 3 lanes × 32-bit, 256 entries. Sits directly downstream of `systolic_controller` and the array.
- Accepts `acc_wr_en`/`acc_wr_addr` with packed column sums, either overwriting or accumulating per lane.
- Performs the 256-cycle sequential clear and reports it through `acc_clear_busy`/`acc_clear_complete`.
- Exposes a registered read port to the activation/unified-buffer stage.

## Interface
Parameters:
- `DEPTH`, 256: number of words; clear length in cycles.
- `ADDR_W`, 8: address width, clog2(DEPTH).
- `LANES`, 3: columns per word.
- `LANE_W`, 32: bits per lane, two's complement.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `acc_clear`  in  1  clear request, level, held by controller.
- `acc_clear_busy`  out  1  sequential clear in progress.
- `acc_clear_complete`  out  1  one-cycle pulse after last entry is cleared.
- `acc_wr_en`  in  1  write request.
- `acc_wr_addr`  in  ADDR_W  write address.
- `acc_wr_data`  in  LANES*LANE_W  lane 0 in bits [31:0].
- `acc_accum`  in  1  1 = add to stored word, 0 = overwrite.
- `rd_en`  in  1  read request.
- `rd_addr`  in  ADDR_W  read address.
- `rd_data`  out  LANES*LANE_W  read result.
- `rd_valid`  out  1  `rd_data` valid.

## Operation
- **Clear start.** Rising edge of `acc_clear` (registered previous value 0, current 1) while not busy.
  - Level-high is never a trigger, so there is no re-trigger while the controller still holds `acc_clear` in the completion cycle.
- **Clear FSM.** States are IDLE and CLEARING, with pointer `clr_ptr`.
  - IDLE→CLEARING on start edge, with `clr_ptr` = 0.
  - In CLEARING, each cycle writes zero at `clr_ptr` and increments it.
  - After writing DEPTH-1: → IDLE, busy drops, complete pulses.
- **Clear priority.** A rising `acc_clear` while already CLEARING is ignored.
- **Write pipeline.** Two-stage read-modify-write.
  - S1: accepted when `acc_wr_en` && !busy && no clear start this cycle. Issues memory read of `acc_wr_addr` and latches addr/data/accum.
  - S2: computes the new word and commits it.
    - Accum: per-lane sum, modulo 2^LANE_W with no saturation or cross-lane carry.
    - Overwrite: `acc_wr_data`.
- **Forwarding.** If S2 commits to the same address S1 is reading, S1 uses S2's result instead of the memory output. Back-to-back accumulates to one address must sum correctly at one per cycle.
- **Writes during clear.** `acc_wr_en` while busy is dropped silently.
  - An S2 write already in flight when clear starts commits normally.
  - If it lands on the address the clear writes that same edge, the clear wins.
- **Read port.** Returns committed memory contents only, with no forwarding from S1/S2.
  - Same-address read and commit on the same edge returns the old value.
  - Reads are serviced during clear and return whatever is stored.
- **Reset.** Memory contents are not reset and are undefined until the first clear completes.
- **Reset mid-clear.** Aborts: FSM → IDLE, pipeline is flushed, entries not yet cleared stay undefined.

## Timing
- **Reset values.** `acc_clear_busy`=0, `acc_clear_complete`=0, `rd_data`=0, `rd_valid`=0. Edge-detect register, `clr_ptr`, and S1/S2 valids are all 0.
- **Clear.** `acc_clear` rises and is sampled at edge E.
  - Busy is high from E to E+DEPTH, i.e. 256 cycles.
  - Entry k is zeroed at edge E+1+k.
  - Complete is high for the single cycle after edge E+DEPTH.
- **Write latency.** `acc_wr_en` sampled at edge W leaves the word committed at edge W+1. A read sampled at W+1 or later sees the new value.
- **Read latency.** `rd_en` sampled at edge R gives `rd_data`/`rd_valid` valid after R. `rd_valid` is high for one cycle per accepted read; `rd_data` holds its value otherwise.
- **Throughput.** One write per cycle, one read per cycle, concurrently.

## Structure
- **Package `tpu_acc_pkg`.**
  - Constants: `ACC_LANES`=3, `ACC_LANE_W`=32, `ACC_WORD_W`=96, `ACC_DEPTH`=256, `ACC_ADDR_W`=8.
  - Clear-state enum `acc_clr_state_t` {ACC_IDLE, ACC_CLEARING}.
- **Sub-module `acc_mem_dp`.**
  - Simple dual-port RAM: two synchronous read ports (RMW, external), one write port, read-before-write, no reset.
  - The clear write and S2 write are muxed onto the single write port, with clear priority.

## Test plan
- **Clear.** Clear after reset, `acc_clear` held until complete.
  - Busy high exactly 256 cycles; complete pulses once; no second clear while `acc_clear` stays high one extra cycle.
  - Reads of addresses 0, 128, 255 return 0.
- **Overwrite.** Write 0x00000003_00000002_00000001 to addr 5, then read addr 5 two cycles later. Expect the same word with `rd_valid`=1.
- **Back-to-back accumulate.** Clear, then accumulate to addr 7 on 4 consecutive cycles: lane0 +1, lane1 +10, lane2 -1 (0xFFFFFFFF).
  - Read gives lane0=4, lane1=40, lane2=0xFFFFFFFC, which proves forwarding.
- **Lane wrap.** Overwrite lane0=0xFFFFFFFF, then accumulate lane0 +2. Expect lane0=0x00000001 and lanes 1/2 unaffected.
- **Write vs clear.** Write issued one cycle before the clear rising edge plus `acc_wr_en` held during busy. After complete, all entries are 0 and no dropped write resurfaces.
- **Reset mid-clear.** Assert `rst_n`=0 at clear cycle 100. Outputs return to reset values; a new clear afterwards completes in 256 cycles.
